pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-009 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  oldest held payload.
REQ-011 SHALL have port occupancy  output  2  entries held, 0..2.

Function
REQ-012 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-013 SHALL hold at most two entries: main register (drives out_data) and skid register.
REQ-014 SHALL implement states EMPTY (occupancy 0), ONE (1) and TWO (2).
REQ-015 SHALL drive in_ready, out_valid and out_data directly from registers, with no combinational path from any input to any output.
REQ-016 SHALL drive in_ready = 1 in EMPTY and ONE, and in_ready = 0 in TWO.
REQ-017 SHALL drive out_valid = 1 in ONE and TWO, and out_valid = 0 in EMPTY.
REQ-018 SHALL, in EMPTY, on in_fire load main <= in_data and go to ONE; otherwise stay in EMPTY.
REQ-019 SHALL, in ONE, on in_fire & out_fire load main <= in_data and stay in ONE.
REQ-020 SHALL, in ONE, on in_fire & !out_fire load skid <= in_data and go to TWO.
REQ-021 SHALL, in ONE, on !in_fire & out_fire go to EMPTY.
REQ-022 SHALL, in ONE, with neither fire, hold state and data.
REQ-023 SHALL, in TWO, on out_fire load main <= skid and go to ONE; otherwise hold state and data.
REQ-024 SHALL have latency of exactly one cycle from in_fire into EMPTY to out_valid = 1 with that data.
REQ-025 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-026 SHALL keep out_data stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL deliver entries in acceptance order, with no loss or duplication absent flush.
REQ-028 SHALL, on flush, go to EMPTY in the next cycle and discard both entries and any same-cycle in_fire; flush SHALL dominate all other transitions.
REQ-029 SHALL NOT change data register contents on flush; only validity is cleared.

Reset
REQ-030 SHALL, on reset, go to EMPTY with in_ready = 1, out_valid = 0, occupancy = 0 and out_data = 0 in the next cycle.
REQ-031 SHALL give reset priority over flush and over both handshakes, including mid-transfer in state TWO.
REQ-032 SHALL clear the skid register to 0 on reset.

Structure
REQ-033 SHALL place the state encodings EMPTY=2'd0, ONE=2'd1 and TWO=2'd2 in the shared pipeline package, where occupancy SHALL equal the state encoding.
REQ-034 SHALL be a single module with no sub-modules; WIDTH=32 instances replace fixed-width stage registers where backpressure is needed.

Verification
REQ-035 SHALL cover: reset, then in_valid=1 with in_data=0x11 and out_ready=1 -> out_valid=1 and out_data=0x11 one cycle later, with occupancy=1.
REQ-036 SHALL cover: out_ready=0, then accept 0xA and 0xB -> occupancy=2 and in_ready=0; then out_ready=1 -> 0xA and 0xB emitted on consecutive cycles.
REQ-037 SHALL cover: out_ready=1 with a 100-word streaming increment from 0 -> 100 outputs 0..99, in order, one per cycle.
REQ-038 SHALL cover: occupancy=2, then flush with in_valid=1 and in_data=0x55 -> next cycle occupancy=0, out_valid=0 and 0x55 never emitted.
REQ-039 SHALL cover: occupancy=2, then reset and flush asserted together -> next cycle EMPTY, out_data=0 and in_ready=1.
REQ-040 SHALL cover: random in_valid/out_ready for 10k cycles -> scoreboard shows order preserved, out_data stable while stalled, and occupancy never exceeds 2.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: shared pipeline state encodings, where occupancy equals the state value
package pipe_skid_reg_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid register with fully registered handshake outputs
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic load_main, load_skid, main_from_skid;
  logic in_fire, out_fire;
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // next state and register load enables; flush overrides every transition and load
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        load_main = in_fire;
        state_nxt = in_fire ? ONE : EMPTY;
      end
      ONE: begin
        load_main = in_fire & out_fire;
        load_skid = in_fire & ~out_fire;
        state_nxt = (in_fire & ~out_fire) ? TWO : (~in_fire & out_fire) ? EMPTY : ONE;
      end
      TWO: begin
        load_main      = out_fire;
        main_from_skid = 1'b1;
        state_nxt      = out_fire ? ONE : TWO;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else state <= state_nxt;
  end
  // data registers; flush leaves contents untouched, only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: queue-model scoreboard plus directed scenarios for pipe_skid_reg
module tb_pipe_skid_reg;
  logic clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0] occupancy;
  int checks = 0, errors = 0;
  logic live = 1'b0;
  logic [31:0] q[$];
  logic [31:0] emitted[$];
  logic [31:0] got[$];
  logic stalled = 1'b0;
  logic [31:0] held;

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a FIFO of at most two entries; accept when fewer than two held
  always @(posedge clk) begin
    automatic logic acc = in_valid && q.size() < 2;
    automatic logic dlv = out_ready && q.size() > 0;
    stalled = 1'b0;
    if (reset) begin
      q.delete();
      live = 1'b1;
    end else if (flush) q.delete();
    else begin
      if (q.size() > 0 && !out_ready) begin
        stalled = 1'b1;
        held = q[0];
      end
      if (dlv) begin
        emitted.push_back(q[0]);
        void'(q.pop_front());
      end
      if (acc) q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("occupancy", {30'b0, occupancy}, q.size());
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      if (stalled) chk("stall_stable", out_data, held);
    end
  end

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl, input logic rs);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; reset = rs;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n, cyc;
    drive(0, 0, 0, 0, 1);
    tick; tick;
    drive(0, 0, 0, 0, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_occ", {30'b0, occupancy}, 0);
    chk("rst_out_data", out_data, 0);
    drive(1, 32'h11, 1, 0, 0);
    tick;
    drive(0, 0, 1, 0, 0);
    chk("lat_valid", {31'b0, out_valid}, 1);
    chk("lat_data", out_data, 32'h11);
    chk("lat_occ", {30'b0, occupancy}, 1);
    tick;
    drive(1, 32'hA, 0, 0, 0); tick;
    drive(1, 32'hB, 0, 0, 0); tick;
    drive(0, 0, 0, 0, 0);
    chk("bp_occ", {30'b0, occupancy}, 2);
    chk("bp_in_ready", {31'b0, in_ready}, 0);
    chk("bp_first", out_data, 32'hA);
    drive(0, 0, 1, 0, 0); tick;
    chk("bp_second_valid", {31'b0, out_valid}, 1);
    chk("bp_second", out_data, 32'hB);
    tick;
    chk("bp_drained", {31'b0, out_valid}, 0);
    emitted.delete();
    n = 0; cyc = 0;
    while (n < 100 && cyc < 300) begin
      drive(1, n, 1, 0, 0);
      if (out_valid) got.push_back(out_data);
      if (in_ready) n++;
      tick;
      cyc++;
    end
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (out_valid) got.push_back(out_data);
      tick;
    end
    chk("stream_cycles", cyc, 100);
    chk("stream_count", got.size(), 100);
    chk("model_count", emitted.size(), 100);
    for (int i = 0; i < got.size() && i < 100; i++) begin
      if (got[i] !== i) begin
        chk("stream_order", got[i], i);
        break;
      end
    end
    for (int i = 0; i < emitted.size() && i < 100; i++) begin
      if (emitted[i] !== i) begin
        chk("model_order", emitted[i], i);
        break;
      end
    end
    drive(1, 32'hC, 0, 0, 0); tick;
    drive(1, 32'hD, 0, 0, 0); tick;
    chk("fl_pre_occ", {30'b0, occupancy}, 2);
    drive(1, 32'h55, 0, 1, 0); tick;
    drive(0, 0, 1, 0, 0);
    chk("fl_occ", {30'b0, occupancy}, 0);
    chk("fl_valid", {31'b0, out_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("fl_no_55", {31'b0, out_valid}, 0);
    end
    drive(1, 32'hE, 0, 0, 0); tick;
    drive(1, 32'hF, 0, 0, 0); tick;
    chk("rf_pre_occ", {30'b0, occupancy}, 2);
    drive(1, 32'h77, 1, 1, 1); tick;
    drive(0, 0, 0, 0, 0);
    chk("rf_occ", {30'b0, occupancy}, 0);
    chk("rf_data", out_data, 0);
    chk("rf_in_ready", {31'b0, in_ready}, 1);
    chk("rf_valid", {31'b0, out_valid}, 0);
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 99) == 0, $urandom_range(0, 499) == 0);
      tick;
    end
    drive(0, 0, 0, 0, 0);
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
